counter_updown_bounded: RTL and testbench

//   Parametrised up/down counter with a runtime-programmable range [lo, hi].

---
 rtl/counter_updown_bounded.sv | 110 +++++++++++
 tb/tb_counter_updown_bounded.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_bounded.sv
// Bounded up/down counter with runtime range [lo, hi], saturate or wrap at the
// bounds, overflow/underflow pulses and sticky flags.
module counter_updown_bounded #(
    parameter int WIDTH   = 8,
    parameter int STEP    = 1,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic             sat,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf,
    output logic             ovf_stk,
    output logic             unf_stk,
    output logic             cfg_err
);

    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             ovf_stk_reg, ovf_stk_next;
    logic             unf_stk_reg, unf_stk_next;

    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic             up_over;
    logic             dn_under;
    logic             inc_only;
    logic             dec_only;

    // One extra bit keeps the carry/borrow so a step past either end of the
    // WIDTH-bit range is seen as a boundary crossing, not a modular wrap.
    assign up_sum   = {1'b0, cnt_reg} + STEP_W;
    assign dn_diff  = {1'b0, cnt_reg} - STEP_W;
    assign up_over  = up_sum > {1'b0, hi};
    assign dn_under = dn_diff[WIDTH] || (dn_diff[WIDTH-1:0] < lo);

    assign cfg_err  = lo > hi;
    assign inc_only = inc & ~dec & ~cfg_err;
    assign dec_only = dec & ~inc & ~cfg_err;

    always_comb begin
        cnt_next     = cnt_reg;
        ovf_next     = 1'b0;
        unf_next     = 1'b0;
        ovf_stk_next = ovf_stk_reg;
        unf_stk_next = unf_stk_reg;
        if (clr) begin
            cnt_next     = RST_W;
            ovf_stk_next = 1'b0;
            unf_stk_next = 1'b0;
        end else if (load) begin
            cnt_next = load_val;
        end else if (inc_only) begin
            if (up_over) begin
                ovf_next     = 1'b1;
                ovf_stk_next = 1'b1;
                cnt_next     = sat ? hi : lo;
            end else begin
                cnt_next = up_sum[WIDTH-1:0];
            end
        end else if (dec_only) begin
            if (dn_under) begin
                unf_next     = 1'b1;
                unf_stk_next = 1'b1;
                cnt_next     = sat ? lo : hi;
            end else begin
                cnt_next = dn_diff[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= RST_W;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
            ovf_stk_reg <= 1'b0;
            unf_stk_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            ovf_reg     <= ovf_next;
            unf_reg     <= unf_next;
            ovf_stk_reg <= ovf_stk_next;
            unf_stk_reg <= unf_stk_next;
        end
    end

    assign cnt     = cnt_reg;
    assign ovf     = ovf_reg;
    assign unf     = unf_reg;
    assign ovf_stk = ovf_stk_reg;
    assign unf_stk = unf_stk_reg;
    assign at_max  = cnt_reg >= hi;
    assign at_min  = cnt_reg <= lo;

endmodule

// File: tb/tb_counter_updown_bounded.sv
// Scoreboard bench: two counters (STEP=1 and STEP=4) share stimulus and are
// checked against an integer-arithmetic reference model.
module tb_counter_updown_bounded;

    logic       clk;
    logic       rst_n;
    logic       clr, load, inc, dec, sat;
    logic [7:0] load_val, lo, hi;
    logic [7:0] cnt_o [2];
    logic [1:0] at_max_o, at_min_o, ovf_o, unf_o, ovf_stk_o, unf_stk_o, cfg_o;

    counter_updown_bounded #(.WIDTH(8), .STEP(1), .RST_VAL(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .sat(sat), .lo(lo), .hi(hi),
        .cnt(cnt_o[0]), .at_max(at_max_o[0]), .at_min(at_min_o[0]),
        .ovf(ovf_o[0]), .unf(unf_o[0]), .ovf_stk(ovf_stk_o[0]),
        .unf_stk(unf_stk_o[0]), .cfg_err(cfg_o[0])
    );

    counter_updown_bounded #(.WIDTH(8), .STEP(4), .RST_VAL(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .inc(inc), .dec(dec), .sat(sat), .lo(lo), .hi(hi),
        .cnt(cnt_o[1]), .at_max(at_max_o[1]), .at_min(at_min_o[1]),
        .ovf(ovf_o[1]), .unf(unf_o[1]), .ovf_stk(ovf_stk_o[1]),
        .unf_stk(unf_stk_o[1]), .cfg_err(cfg_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int unsigned tgt;
        int          cnt [2];
        bit          o [2];
        bit          u [2];
        bit          os [2];
        bit          us [2];
    } exp_t;

    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: what the counters should hold after the last
    // issued request.
    int m_cnt [2] = '{0, 0};
    bit m_os  [2] = '{0, 0};
    bit m_us  [2] = '{0, 0};

    task automatic chk(input string name, input int lane, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s lane%0d @cyc %0d: got %0d expected %0d", name, lane, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit c, input bit l, input int lv, input bit i,
                         input bit d, input bit s, input int lo_v, input int hi_v);
        exp_t e;
        @(posedge clk);
        #1;
        clr = c; load = l; load_val = 8'(lv); inc = i; dec = d; sat = s;
        lo = 8'(lo_v); hi = 8'(hi_v);
        e.tgt = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            int st;
            bit o, u;
            st = (k == 0) ? 1 : 4;
            o = 1'b0;
            u = 1'b0;
            if (c) begin
                m_cnt[k] = 0; m_os[k] = 1'b0; m_us[k] = 1'b0;
            end else if (l) begin
                m_cnt[k] = lv;
            end else if (lo_v > hi_v || i == d) begin
                m_cnt[k] = m_cnt[k];
            end else if (i) begin
                if (m_cnt[k] + st > hi_v) begin
                    o = 1'b1; m_os[k] = 1'b1;
                    m_cnt[k] = s ? hi_v : lo_v;
                end else begin
                    m_cnt[k] = m_cnt[k] + st;
                end
            end else begin
                if (m_cnt[k] - st < lo_v) begin
                    u = 1'b1; m_us[k] = 1'b1;
                    m_cnt[k] = s ? lo_v : hi_v;
                end else begin
                    m_cnt[k] = m_cnt[k] - st;
                end
            end
            e.cnt[k] = m_cnt[k];
            e.o[k] = o; e.u[k] = u; e.os[k] = m_os[k]; e.us[k] = m_us[k];
        end
        sb.push_back(e);
    endtask

    // Monitor: every clock edge presents a result; compare those whose
    // request has reached its edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tgt <= cyc) begin
                e = sb.pop_front();
                for (int k = 0; k < 2; k++) begin
                    chk("cnt", k, int'(cnt_o[k]), e.cnt[k]);
                    chk("ovf", k, int'(ovf_o[k]), int'(e.o[k]));
                    chk("unf", k, int'(unf_o[k]), int'(e.u[k]));
                    chk("ovf_stk", k, int'(ovf_stk_o[k]), int'(e.os[k]));
                    chk("unf_stk", k, int'(unf_stk_o[k]), int'(e.us[k]));
                    chk("at_max", k, int'(at_max_o[k]), int'(e.cnt[k] >= int'(hi)));
                    chk("at_min", k, int'(at_min_o[k]), int'(e.cnt[k] <= int'(lo)));
                    chk("cfg_err", k, int'(cfg_o[k]), int'(lo > hi));
                end
            end
        end
    end

    task automatic drain();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b;
        int cur_lo, cur_hi;
        rst_n = 1'b1;
        clr = 0; load = 0; load_val = 0; inc = 0; dec = 0; sat = 0; lo = 0; hi = 255;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_cnt", k, int'(cnt_o[k]), 0);
            chk("rst_flags", k, int'({ovf_o[k], unf_o[k], ovf_stk_o[k], unf_stk_o[k]}), 0);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Reach 37 with a sticky ovf and a live ovf pulse, then reset mid-cycle.
        drive(0, 1, 36, 0, 0, 1, 0, 37);
        drive(0, 0, 0, 1, 0, 1, 0, 37);
        drive(0, 0, 0, 1, 0, 1, 0, 37);
        drain();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_cnt", k, int'(cnt_o[k]), 0);
            chk("async_rst_flags", k, int'({ovf_o[k], unf_o[k], ovf_stk_o[k], unf_stk_o[k]}), 0);
        end
        clr = 0; load = 0; inc = 0; dec = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_os[k] = 1'b0; m_us[k] = 1'b0;
        end

        // Saturate at hi.
        drive(0, 1, 19, 0, 0, 1, 10, 20);
        repeat (3) drive(0, 0, 0, 1, 0, 1, 10, 20);
        // Wrap both ways.
        drive(0, 1, 10, 0, 0, 0, 10, 20);
        drive(0, 0, 0, 0, 1, 0, 10, 20);
        drive(0, 0, 0, 1, 0, 0, 10, 20);
        // Priority and simultaneous requests.
        drive(0, 1, 15, 0, 0, 0, 10, 20);
        drive(0, 0, 0, 1, 1, 0, 10, 20);
        drive(1, 1, 99, 1, 0, 0, 10, 20);
        drive(0, 1, 42, 1, 0, 0, 10, 20);
        // Full-range wrap, mostly exercising the STEP=4 counter.
        drive(0, 1, 253, 0, 0, 0, 0, 255);
        drive(0, 0, 0, 1, 0, 0, 0, 255);
        drive(0, 1, 2, 0, 0, 0, 0, 255);
        drive(0, 0, 0, 0, 1, 0, 0, 255);
        // lo == hi and out-of-range loaded values.
        drive(0, 1, 200, 0, 0, 1, 50, 50);
        drive(0, 0, 0, 1, 0, 1, 50, 50);
        drive(0, 0, 0, 0, 1, 0, 50, 50);
        drive(0, 1, 5, 0, 0, 0, 50, 60);
        drive(0, 0, 0, 0, 1, 1, 50, 60);

        // Illegal range: inc/dec must have no effect.
        drive(0, 1, 25, 0, 0, 0, 0, 255);
        for (int n = 0; n < 2000; n++)
            drive(0, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 30, 20);

        // Random legal operation with occasional bound changes.
        cur_lo = 10; cur_hi = 200;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                a = $urandom_range(0, 255);
                b = ($urandom_range(0, 7) == 0) ? a : $urandom_range(0, 255);
                cur_lo = (a < b) ? a : b;
                cur_hi = (a < b) ? b : a;
            end
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 255), 1'($urandom), 1'($urandom), 1'($urandom),
                  cur_lo, cur_hi);
        end

        for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
        #1;
        if (sb.size() > 0) chk("sb_drain", 0, sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
